// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: issues sequential reads to a 1-cycle-latency SRAM,
// buffers {pc,inst} pairs in a DEPTH-entry FIFO and hands them to decode via valid/ready.
module inst_fetch_queue #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic                     inst_sram_en,
  output logic [ADDR_W-1:0]        inst_sram_addr,
  input  logic [DATA_W-1:0]        inst_sram_rdata,
  input  logic                     flush_i,
  input  logic [ADDR_W-1:0]        flush_pc_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [DATA_W-1:0]        out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned       PTR_W   = $clog2(DEPTH);
  localparam int unsigned       CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]    L_DEPTH = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] L_STEP  = ADDR_W'(PC_STEP);

  typedef enum logic [0:0] {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   r_req_pc;
  logic                r_inflight;
  logic                r_drop;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [ADDR_W-1:0]   r_mem_pc   [DEPTH];
  logic [DATA_W-1:0]   r_mem_inst [DEPTH];
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic [CNT_W:0]      w_credit_use;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a single idle BOOT cycle, then RUN forever
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Issue decision: credit counts queued entries plus the response in flight,
  // so a same-cycle pop only frees a slot from the next cycle on
  always_comb begin
    w_credit_use = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    w_issue      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!flush_i && (w_credit_use < L_DEPTH)) begin
          w_issue = 1'b1;
        end else begin
          w_issue = 1'b0;
        end
      end
      default: w_issue = 1'b0;
    endcase
  end

  assign inst_sram_en   = w_issue;
  assign inst_sram_addr = r_fetch_pc;
  assign w_push         = r_inflight && !r_drop && !flush_i;
  assign w_pop          = (r_count != {CNT_W{1'b0}}) && out_ready && !flush_i;

  // Fetch PC, request PC and in-flight/drop tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= {ADDR_W{1'b0}};
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (flush_i) begin
        r_fetch_pc <= flush_pc_i;
        r_drop     <= w_issue;
      end else begin
        if (w_issue) begin
          r_fetch_pc <= r_fetch_pc + L_STEP;
          r_req_pc   <= r_fetch_pc;
        end
        if (r_inflight) begin
          r_drop <= 1'b0;
        end
      end
    end
  end

  // FIFO storage, pointers and occupancy; flush outranks push and pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]   <= {ADDR_W{1'b0}};
        r_mem_inst[i] <= {DATA_W{1'b0}};
      end
    end else if (flush_i) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem_pc[r_wr_ptr]   <= r_req_pc;
        r_mem_inst[r_wr_ptr] <= inst_sram_rdata;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = (r_count != {CNT_W{1'b0}});
  assign out_pc    = r_mem_pc[r_rd_ptr];
  assign out_inst  = r_mem_inst[r_rd_ptr];
  assign count     = r_count;

endmodule
